// File: rtl/placar_ataque_pkg.sv
// Shared types and helpers for the ATAQUE-phase scoreboard: FSM encoding,
// BCD digit width and BCD/binary conversion.
package placar_ataque_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        JOGANDO = 3'd2,
        VITORIA = 3'd3,
        DERROTA = 3'd4
    } estado_t;

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
        return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
    endfunction

    function automatic logic [7:0] bin_to_bcd(input int unsigned v);
        logic [3:0] dez;
        logic [3:0] uni;
        dez = 4'((v / 10) % 10);
        uni = 4'(v % 10);
        return {dez, uni};
    endfunction

endpackage

// File: rtl/placar_ataque_contador_bcd2.sv
// Two-digit BCD up/down counter with synchronous load; load beats increment,
// increment beats decrement, and decrement saturates at 00.
module contador_bcd2
    import placar_ataque_pkg::*;
#(
    parameter logic [7:0] VALOR_RESET = 8'h00
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             carregar,
    input  logic [7:0]       valor_carga,
    input  logic             incrementa,
    input  logic             decrementa,
    output logic [BCD_W-1:0] dez,
    output logic [BCD_W-1:0] uni
);

    logic [BCD_W-1:0] dez_q, dez_d;
    logic [BCD_W-1:0] uni_q, uni_d;

    always_comb begin
        // NOTE: defaults first so every path assigns both digits and no latch is inferred.
        dez_d = dez_q;
        uni_d = uni_q;
        if (carregar) begin
            dez_d = valor_carga[7:4];
            uni_d = valor_carga[3:0];
        end else if (incrementa) begin
            if (uni_q == 4'd9) begin
                uni_d = 4'd0;
                dez_d = dez_q + 4'd1;
            end else begin
                uni_d = uni_q + 4'd1;
            end
        end else if (decrementa && (dez_q != 4'd0 || uni_q != 4'd0)) begin
            if (uni_q == 4'd0) begin
                uni_d = 4'd9;
                dez_d = dez_q - 4'd1;
            end else begin
                uni_d = uni_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            dez_q <= VALOR_RESET[7:4];
            uni_q <= VALOR_RESET[3:0];
        end else begin
            dez_q <= dez_d;
            uni_q <= uni_d;
        end
    end

    assign dez = dez_q;
    assign uni = uni_q;

endmodule

// File: rtl/placar_ataque.sv
// ATAQUE-phase scoreboard: counts hits and remaining shots in BCD and decides
// VITORIA/DERROTA from the per-shot result pulse of the attack manager.
module placar_ataque
    import placar_ataque_pkg::*;
#(
    parameter int MAX_TIROS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [34:0]      mapa,
    input  logic             tiro,
    input  logic             acerto,
    input  logic             repetido,
    output logic [BCD_W-1:0] acertos_dez,
    output logic [BCD_W-1:0] acertos_uni,
    output logic [BCD_W-1:0] restantes_dez,
    output logic [BCD_W-1:0] restantes_uni,
    output logic [5:0]       total_navios,
    output logic             jogando,
    output logic             vitoria,
    output logic             derrota
);

    localparam logic [7:0] RESTANTES_INI = bin_to_bcd(MAX_TIROS);

    function automatic logic [5:0] popcount(input logic [34:0] m);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 35; i++) n = n + 6'(m[i]);
        return n;
    endfunction

    estado_t    estado_q, estado_d;
    logic [5:0] total_q, total_d;
    logic       tiro_valido, recarrega;
    logic [6:0] acertos_prox, restantes_bin;

    assign tiro_valido   = enable && (estado_q == JOGANDO) && tiro && !repetido;
    assign recarrega     = !enable || (estado_q == OCIOSO) || (estado_q == CARREGA);
    assign acertos_prox  = bcd_to_bin({acertos_dez, acertos_uni}) + 7'(acerto);
    assign restantes_bin = bcd_to_bin({restantes_dez, restantes_uni});

    contador_bcd2 #(.VALOR_RESET(8'h00)) u_acertos (
        .clock       (clock),
        .reset       (reset),
        .carregar    (recarrega),
        .valor_carga (8'h00),
        .incrementa  (tiro_valido && acerto),
        .decrementa  (1'b0),
        .dez         (acertos_dez),
        .uni         (acertos_uni)
    );

    contador_bcd2 #(.VALOR_RESET(RESTANTES_INI)) u_restantes (
        .clock       (clock),
        .reset       (reset),
        .carregar    (recarrega),
        .valor_carga (RESTANTES_INI),
        .incrementa  (1'b0),
        .decrementa  (tiro_valido),
        .dez         (restantes_dez),
        .uni         (restantes_uni)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            total_q  <= 6'd0;
        end else begin
            estado_q <= estado_d;
            total_q  <= total_d;
        end
    end

    always_comb begin
        total_d = total_q;
        if (enable && estado_q == CARREGA) total_d = popcount(mapa);
    end

    // Victory is checked before defeat so a last-shot hit on the last ship wins.
    always_comb begin
        estado_d = estado_q;
        if (!enable) begin
            estado_d = OCIOSO;
        end else begin
            case (estado_q)
                OCIOSO:  estado_d = CARREGA;
                CARREGA: estado_d = (popcount(mapa) == 6'd0) ? VITORIA : JOGANDO;
                JOGANDO: begin
                    if (tiro_valido) begin
                        if (acertos_prox == {1'b0, total_q}) estado_d = VITORIA;
                        else if (restantes_bin == 7'd1)      estado_d = DERROTA;
                    end
                end
                VITORIA: estado_d = VITORIA;
                DERROTA: estado_d = DERROTA;
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_comb begin
        jogando = (estado_q == JOGANDO);
        vitoria = (estado_q == VITORIA);
        derrota = (estado_q == DERROTA);
    end

    assign total_navios = total_q;

endmodule
